// File: rtl/circle7seg_pkg.sv
// Shared constants and types for the walking-circle seven-segment driver.
// Segment bits are ordered {dp,g,f,e,d,c,b,a}, with a at bit 0.
package circle7seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_COUNT_TO        = 2**DEF_WIDTH - 1;
    localparam int DEF_NUM_OF_DISPLAYS = 6;
    localparam int DEF_COL_WIDTH       = 8;

    // Which perimeter edge the lit segment is on; the display index
    // distinguishes positions along the long top/bottom runs.
    typedef enum logic [2:0] {
        TOP     = 3'd0,
        RIGHT_B = 3'd1,
        RIGHT_C = 3'd2,
        BOTTOM  = 3'd3,
        LEFT_E  = 3'd4,
        LEFT_F  = 3'd5
    } pos_e;

    function automatic int edge_seg(pos_e e);
        case (e)
            TOP:     return SEG_A;
            RIGHT_B: return SEG_B;
            RIGHT_C: return SEG_C;
            BOTTOM:  return SEG_D;
            LEFT_E:  return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/circle7seg_walker_tick_counter.sv
// Free-running prescaler: counts 0..COUNT_TO and flags the terminal count.
module tick_counter #(
    parameter int WIDTH    = 4,
    parameter int COUNT_TO = 2**WIDTH - 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic overflow_o
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(COUNT_TO);

    logic [WIDTH-1:0] cnt;

    assign overflow_o = (cnt == TERM);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           cnt <= '0;
        else if (overflow_o) cnt <= '0;
        else                 cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/circle7seg_walker.sv
// Walks one lit segment clockwise around the outer perimeter of a display row.
// Define CIRCLE7SEG_ACTIVE_LOW_EN to invert all seg7 bits (common-anode).
module circle7seg_walker
    import circle7seg_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int COUNT_TO        = 2**WIDTH - 1,
    parameter int NUM_OF_DISPLAYS = DEF_NUM_OF_DISPLAYS,
    parameter int COL_WIDTH       = DEF_COL_WIDTH,
    localparam int DW             = $clog2(NUM_OF_DISPLAYS)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    output logic                                        overflow_o,
    output logic                                        directie,
    output logic                                        row,
    output logic [DW-1:0]                               curr_display,
    output logic [NUM_OF_DISPLAYS-1:0][COL_WIDTH-1:0]   seg7
);

    localparam logic [DW-1:0] LAST_DISP = DW'(NUM_OF_DISPLAYS - 1);

`ifdef CIRCLE7SEG_ACTIVE_LOW_EN
    localparam logic [COL_WIDTH-1:0] SEG_POL = '1;
`else
    localparam logic [COL_WIDTH-1:0] SEG_POL = '0;
`endif

    pos_e          edge_q, edge_d;
    logic [DW-1:0] disp_q, disp_d;
    logic [COL_WIDTH-1:0] seg_on;

    tick_counter #(
        .WIDTH    (WIDTH),
        .COUNT_TO (COUNT_TO)
    ) u_tick (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .overflow_o (overflow_o)
    );

    // Top run goes left-to-right, bottom run right-to-left; the corners
    // (b/c on the last display, e/f on display 0) hold the index.
    always_comb begin
        edge_d = edge_q;
        disp_d = disp_q;
        case (edge_q)
            TOP: begin
                if (disp_q == LAST_DISP) edge_d = RIGHT_B;
                else                     disp_d = disp_q + 1'b1;
            end
            RIGHT_B: edge_d = RIGHT_C;
            RIGHT_C: edge_d = BOTTOM;
            BOTTOM: begin
                if (disp_q == '0) edge_d = LEFT_E;
                else              disp_d = disp_q - 1'b1;
            end
            LEFT_E: edge_d = LEFT_F;
            default: begin
                edge_d = TOP;
                disp_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_q <= TOP;
            disp_q <= '0;
        end else if (overflow_o) begin
            edge_q <= edge_d;
            disp_q <= disp_d;
        end
    end

    assign curr_display = disp_q;
    assign directie     = (edge_q == BOTTOM) || (edge_q == LEFT_E) || (edge_q == LEFT_F);
    assign row          = (edge_q == RIGHT_C) || (edge_q == BOTTOM) || (edge_q == LEFT_E);

    always_comb begin
        seg_on = '0;
        seg_on[edge_seg(edge_q)] = 1'b1;
    end

    for (genvar i = 0; i < NUM_OF_DISPLAYS; i++) begin : g_disp
        assign seg7[i] = (disp_q == DW'(i)) ? (seg_on ^ SEG_POL) : SEG_POL;
    end

endmodule

// File: tb/tb_circle7seg_walker.sv
// Scoreboard bench: two walkers (COUNT_TO=15 and COUNT_TO=0) against a path-table model.
module tb_circle7seg_walker;
    localparam int N = 6;
    localparam int L = 2*N + 4;
    localparam int CT0 = 15;
    localparam int CT1 = 0;

    typedef logic [63:0] obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                  ovf_a, dir_a, row_a, ovf_b, dir_b, row_b;
    logic [2:0]            cd_a, cd_b;
    logic [N-1:0][7:0]     seg_a, seg_b;

    circle7seg_walker #(.WIDTH(4), .COUNT_TO(CT0), .NUM_OF_DISPLAYS(N), .COL_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .overflow_o(ovf_a), .directie(dir_a),
        .row(row_a), .curr_display(cd_a), .seg7(seg_a));

    circle7seg_walker #(.WIDTH(4), .COUNT_TO(CT1), .NUM_OF_DISPLAYS(N), .COL_WIDTH(8)) dut0 (
        .clk_i(clk), .rst_i(rst), .overflow_o(ovf_b), .directie(dir_b),
        .row(row_b), .curr_display(cd_b), .seg7(seg_b));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input obs_t obs, input obs_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected {ovf,dir,row,disp[2:0],seg7[47:0]} for prescaler count c and path position p.
    function automatic obs_t expect_of(input int c, input int p, input int ct);
        logic [N-1:0][7:0] s;
        logic [7:0] bits;
        int d;
        logic dr, rw;
        if (p < N)             begin d = p;         bits = 8'h01; dr = 0; rw = 0; end
        else if (p == N)       begin d = N-1;       bits = 8'h02; dr = 0; rw = 0; end
        else if (p == N+1)     begin d = N-1;       bits = 8'h04; dr = 0; rw = 1; end
        else if (p <= 2*N+1)   begin d = 2*N+1-p;   bits = 8'h08; dr = 1; rw = 1; end
        else if (p == 2*N+2)   begin d = 0;         bits = 8'h10; dr = 1; rw = 1; end
        else                   begin d = 0;         bits = 8'h20; dr = 1; rw = 0; end
        for (int i = 0; i < N; i++) s[i] = (i == d) ? bits : 8'h00;
`ifdef CIRCLE7SEG_ACTIVE_LOW_EN
        s = ~s;
`endif
        return {10'd0, (c == ct), dr, rw, 3'(d), s};
    endfunction

    obs_t obs_a, obs_b;
    assign obs_a = {10'd0, ovf_a, dir_a, row_a, cd_a, seg_a};
    assign obs_b = {10'd0, ovf_b, dir_b, row_b, cd_b, seg_b};

    int   m_cnt0 = 0, m_p0 = 0, m_cnt1 = 0, m_p1 = 0;
    obs_t qa[$];
    obs_t qb[$];

    // Model: advances on each rising edge and pushes the expected outputs for the new cycle.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_cnt0 = 0; m_p0 = 0; m_cnt1 = 0; m_p1 = 0;
        end else begin
            if (m_cnt0 == CT0) begin m_cnt0 = 0; m_p0 = (m_p0 + 1) % L; end
            else m_cnt0++;
            if (m_cnt1 == CT1) begin m_cnt1 = 0; m_p1 = (m_p1 + 1) % L; end
            else m_cnt1++;
        end
        qa.push_back(expect_of(m_cnt0, m_p0, CT0));
        qb.push_back(expect_of(m_cnt1, m_p1, CT1));
    end

    initial forever begin
        @(negedge clk);
        if (qa.size() > 0) chk("sb_ct15", obs_a, qa.pop_front());
        if (qb.size() > 0) chk("sb_ct0",  obs_b, qb.pop_front());
    end

    initial begin
        bit hit;
        #1;
        chk("rst_init_ct15", obs_a, expect_of(0, 0, CT0));
        chk("rst_init_ct0",  obs_b, expect_of(0, 0, CT1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Well over one lap of the slow walker (16 ticks x 16 cycles).
        repeat (300) @(negedge clk);

        // Asynchronous reset between edges must take effect at once.
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ct15", obs_a, expect_of(0, 0, CT0));
        chk("rst_async_ct0",  obs_b, expect_of(0, 0, CT1));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);

        // Reset during a tick cycle of the slow walker.
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (m_cnt0 == CT0) hit = 1'b1;
        end
        chk("tick_found", obs_t'(hit), obs_t'(1));
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
